max7219_frame_arbiter: RTL and testbench
========================================

Name: max7219_frame_arbiter

Overview:
- Schedules access to the single two-panel MAX7219 display driver (128-bit frame in, start/finish handshake) for two independent frame sources.
- Round-robin arbitration; latches the winner's frame and holds it stable on the driver bus; waits for driver completion with a timeout watchdog.
- Pulses an ack back to the granted source.
- Sits between the pattern/frame generators and the display serializer.

Parameters:
- TIMEOUT_CYCLES, 40000: maximum clk cycles from drv_start to drv_finish before the frame is abandoned. Valid range 1 to 2^TMO_W-1.
- TMO_W, 16: width of the watchdog counter.
- REFRESH_CYCLES, 1000000: idle cycles before the last frame is resent. Used only with the optional feature.
- REF_W, 20: width of the refresh counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- req  input  2  per-source frame request; level, held until ack
- pixels0  input  128  frame from source 0; sampled only in the grant cycle
- pixels1  input  128  frame from source 1; sampled only in the grant cycle
- ack  output  2  one-hot, one-cycle pulse when the granted frame completes or times out
- grant  output  2  one-hot; owner of the driver from grant until ack, 0 otherwise
- tmo  output  1  one-cycle pulse coincident with ack when the frame timed out
- tmo_sticky  output  1  set by any timeout; cleared only by rst
- drv_pixels  output  128  frame to the driver; stable from drv_start until the cycle after drv_finish/timeout
- drv_start  output  1  one-cycle start pulse to the driver
- drv_finish  input  1  one-cycle completion pulse from the driver
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: ack=0, grant=0, tmo=0, tmo_sticky=0, drv_pixels=0, drv_start=0, busy=0. State=IDLE, rr_last=1 (source 0 wins the first tie), counters=0, frame_valid=0.
- Reset mid-operation: all of the above take effect immediately and asynchronously. A drv_finish arriving after reset is ignored in IDLE.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE -> LOAD when req!=0.
  - Winner is the only requester, or on a tie the source that is not rr_last.
  - In the LOAD edge: grant=winner, drv_pixels<=pixels[winner], rr_last<=winner, frame_valid<=1.
- LOAD -> START: drv_start=1 for exactly one cycle. Latency from req rise in IDLE to drv_start high is 2 cycles.
- START -> WAIT: watchdog cleared to 0, then increments each cycle in WAIT.
- WAIT -> DONE on drv_finish, or when the watchdog reaches TIMEOUT_CYCLES-1 (timeout).
  - If drv_finish coincides with the terminal count, it is treated as a finish, not a timeout.
- DONE: ack[winner]=1 for one cycle. On timeout, tmo=1 and tmo_sticky<=1 in the same cycle.
  - grant clears on the following edge; next state is IDLE.
- A source may re-request in the cycle after its ack. Fairness: with both req held continuously, grants alternate 0,1,0,1.
- req dropped while granted: the frame still completes and ack still pulses. No abort exists.
- drv_finish outside WAIT is ignored.
- pixels inputs are don't-care except in the IDLE->LOAD edge.

Optional Feature:
- Macro: MAX7219_ARB_REFRESH_EN.
- When defined:
  - A refresh counter runs only in IDLE with req==0 and frame_valid==1; it clears on leaving IDLE or on any req.
  - At REFRESH_CYCLES-1 it enters LOAD with grant=0 and drv_pixels unchanged (the last frame), then runs START/WAIT/DONE normally. No ack is issued; tmo/tmo_sticky still apply.
  - rr_last is not updated by a refresh.
  - If req rises in the same cycle as the terminal count, the request wins and the counter clears.
- When not defined: no refresh counter or logic is synthesized, the block never starts a frame without req, and REFRESH_CYCLES/REF_W are unused.

Test Plan:
- Single request: req=01, pixels0={01..08,01..08}.
  - drv_start 2 cycles after req; drv_pixels equals pixels0.
  - Driver model finishes 30 cycles later; ack=01 one cycle after drv_finish; grant returns to 00.
- Contention: req=11 held for 4 frames.
  - grant sequence 01,10,01,10; each drv_pixels matches the granted source; no cycle with both grant bits high.
- Timeout: TIMEOUT_CYCLES=16, driver never finishes.
  - ack and tmo pulse 17 cycles after drv_start; tmo_sticky=1 until rst.
  - Next request is still served normally.
- Finish on terminal count: drv_finish exactly at watchdog=TIMEOUT_CYCLES-1 -> ack=1, tmo=0, tmo_sticky=0.
- Reset mid-WAIT: assert rst for 1 cycle.
  - All outputs 0 immediately; a late drv_finish produces no ack.
  - Next tie (req=11) goes to source 0.
- With MAX7219_ARB_REFRESH_EN and REFRESH_CYCLES=100: one frame, then idle.
  - drv_start recurs every ~100+ cycles with the same drv_pixels, grant=00, no ack.
  - A req at the terminal count is served instead of the refresh.

Source files
------------

// File: rtl/max7219_frame_arbiter.sv
// rtl/max7219_frame_arbiter.sv - round-robin arbiter feeding one MAX7219 driver, watchdog on completion
// Optional idle-refresh of the last frame: define MAX7219_ARB_REFRESH_EN.
module max7219_frame_arbiter #(
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int TMO_W          = 16,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int REF_W          = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [127:0] pixels0,
  input  logic [127:0] pixels1,
  output logic [1:0]   ack,
  output logic [1:0]   grant,
  output logic         tmo,
  output logic         tmo_sticky,
  output logic [127:0] drv_pixels,
  output logic         drv_start,
  input  logic         drv_finish,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] wd;
  logic             wd_term;
  logic             timed_out;
  logic             rr_last;
  logic             win;
  logic             refresh_hit;

  assign wd_term = (wd == TMO_W'(TIMEOUT_CYCLES - 1));

  // On a tie the source that did not win last time is served.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)
      win = 1'b1;
    else if (req == 2'b11)
      win = ~rr_last;
  end

  always_comb begin
    state_nxt = state;
    drv_start = 1'b0;
    busy      = 1'b1;
    ack       = 2'b00;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00 || refresh_hit)
          state_nxt = LOAD;
      end
      LOAD:  state_nxt = START;
      START: begin
        drv_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (drv_finish || wd_term)
          state_nxt = DONE;
      end
      DONE: begin
        ack       = grant;
        tmo       = timed_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      drv_pixels <= '0;
      rr_last    <= 1'b1;
      wd         <= '0;
      timed_out  <= 1'b0;
      tmo_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // A refresh (no req) leaves grant at 0 and the last frame in place.
          if (req != 2'b00) begin
            grant      <= win ? 2'b10 : 2'b01;
            drv_pixels <= win ? pixels1 : pixels0;
            rr_last    <= win;
          end
        end
        START: begin
          wd        <= '0;
          timed_out <= 1'b0;
        end
        WAIT: begin
          wd        <= wd + TMO_W'(1);
          // A finish on the terminal count wins over the timeout.
          timed_out <= wd_term && !drv_finish;
        end
        DONE: begin
          grant <= 2'b00;
          if (timed_out)
            tmo_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAX7219_ARB_REFRESH_EN
  logic [REF_W-1:0] ref_cnt;
  logic             frame_valid;
  logic             ref_run;

  assign ref_run     = (state == IDLE) && (req == 2'b00) && frame_valid;
  assign refresh_hit = ref_run && (ref_cnt == REF_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt     <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (state == IDLE && req != 2'b00)
        frame_valid <= 1'b1;
      if (ref_run && !refresh_hit)
        ref_cnt <= ref_cnt + REF_W'(1);
      else
        ref_cnt <= '0;
    end
  end
`else
  logic [REF_W-1:0] ref_unused;

  assign refresh_hit = 1'b0;
  assign ref_unused  = REF_W'(REFRESH_CYCLES);
`endif

endmodule

// File: tb/tb_max7219_frame_arbiter.sv
// tb/tb_max7219_frame_arbiter.sv - table, directed and randomized checks of max7219_frame_arbiter
module tb_max7219_frame_arbiter;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [127:0] pixels0;
  logic [127:0] pixels1;
  logic [1:0]   ack;
  logic [1:0]   grant;
  logic         tmo;
  logic         tmo_sticky;
  logic [127:0] drv_pixels;
  logic         drv_start;
  logic         drv_finish;
  logic         busy;

  int vectors = 0;
  int errors  = 0;
  bit last_m;
  bit sticky_m;

  max7219_frame_arbiter #(.TIMEOUT_CYCLES(TMO), .TMO_W(16), .REFRESH_CYCLES(100), .REF_W(20)) dut (
    .clk(clk), .rst(rst), .req(req), .pixels0(pixels0), .pixels1(pixels1),
    .ack(ack), .grant(grant), .tmo(tmo), .tmo_sticky(tmo_sticky),
    .drv_pixels(drv_pixels), .drv_start(drv_start), .drv_finish(drv_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    int         d;
    bit         drop;
    logic [1:0] exp_g;
    bit         exp_t;
    int         exp_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference arbitration: sole requester wins, a tie goes to the source not served last.
  function automatic logic [1:0] pick(input logic [1:0] r);
    bit w;
    if (r == 2'b01)      w = 1'b0;
    else if (r == 2'b10) w = 1'b1;
    else                 w = ~last_m;
    last_m = w;
    return w ? 2'b10 : 2'b01;
  endfunction

  // d = cycles from drv_start to the driver's finish pulse
  task automatic run_txn(input logic [1:0] r, input int d, input bit drop,
                         input logic [127:0] p0, input logic [127:0] p1,
                         input logic [1:0] exp_g, input bit exp_t, input int exp_lat);
    int n;
    bit both;
    logic [127:0] exp_pix;
    exp_pix = exp_g[1] ? p1 : p0;
    pixels0 = p0;
    pixels1 = p1;
    req     = r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        pixels0 = ~p0;
        pixels1 = ~p1;
      end
    end while (!drv_start && n < 10);
    chk("start_latency", n, 2);
    chk("grant", grant, exp_g);
    chk("drv_pixels", drv_pixels, exp_pix);
    if (drop) req = 2'b00;
    n = 0;
    both = 1'b0;
    while (1) begin
      @(negedge clk);
      drv_finish = 1'b0;
      n++;
      if (grant == 2'b11) both = 1'b1;
      if (ack != 2'b00 || n >= 40) break;
      if (n == d) drv_finish = 1'b1;
    end
    chk("ack_latency", n, exp_lat);
    chk("ack", ack, exp_g);
    chk("tmo", tmo, exp_t);
    chk("drv_pixels_hold", drv_pixels, exp_pix);
    chk("grant_onehot", both, 0);
    req = 2'b00;
    sticky_m = sticky_m | exp_t;
    @(negedge clk);
    chk("grant_release", grant, 2'b00);
    chk("ack_pulse", ack, 2'b00);
    chk("busy_idle", busy, 0);
    chk("tmo_sticky", tmo_sticky, sticky_m);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    bit any_ack;
    bit both;
    logic [1:0] r, g;
    logic [127:0] p0, p1;
    int d;
    bit t;

    tbl[0] = '{2'b01, 12, 1'b0, 2'b01, 1'b0, 13};
    tbl[1] = '{2'b11,  3, 1'b0, 2'b10, 1'b0,  4};
    tbl[2] = '{2'b11, 16, 1'b0, 2'b01, 1'b0, 17};
    tbl[3] = '{2'b10,  1, 1'b0, 2'b10, 1'b0,  2};
    tbl[4] = '{2'b01, 20, 1'b0, 2'b01, 1'b1, 17};
    tbl[5] = '{2'b10,  7, 1'b1, 2'b10, 1'b0,  8};
    tbl[6] = '{2'b11, 17, 1'b0, 2'b01, 1'b1, 17};

    rst = 1'b1;
    req = 2'b00;
    pixels0 = '0;
    pixels1 = '0;
    drv_finish = 1'b0;
    sticky_m = 1'b0;
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_tmo_sticky", tmo_sticky, 0);
    chk("rst_drv_pixels", drv_pixels, 0);
    chk("rst_drv_start", drv_start, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      p0 = (i == 0) ? 128'h0102030405060708_0102030405060708 : rnd128();
      p1 = rnd128();
      run_txn(tbl[i].req, tbl[i].d, tbl[i].drop, p0, p1, tbl[i].exp_g, tbl[i].exp_t, tbl[i].exp_lat);
    end

    // Reset in the middle of WAIT, then a stray finish pulse
    req = 2'b01;
    pixels0 = rnd128();
    n = 0;
    do begin @(negedge clk); n++; end while (!drv_start && n < 10);
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drv_pixels", drv_pixels, 0);
    chk("arst_tmo_sticky", tmo_sticky, 0);
    chk("arst_ack", ack, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    sticky_m = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    drv_finish = 1'b1;
    @(negedge clk);
    drv_finish = 1'b0;
    any_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) any_ack = 1'b1;
    end
    chk("late_finish_ignored", any_ack, 0);

    // Continuous contention after reset: grants alternate starting with source 0
    req = 2'b11;
    both = 1'b0;
    for (int f = 0; f < 4; f++) begin
      p0 = rnd128();
      p1 = rnd128();
      pixels0 = p0;
      pixels1 = p1;
      g = f[0] ? 2'b10 : 2'b01;
      n = 0;
      do begin @(negedge clk); n++; end while (!drv_start && n < 20);
      chk("cont_start", drv_start, 1);
      chk("cont_grant", grant, g);
      chk("cont_pixels", drv_pixels, f[0] ? p1 : p0);
      n = 0;
      while (1) begin
        @(negedge clk);
        drv_finish = 1'b0;
        n++;
        if (grant == 2'b11) both = 1'b1;
        if (ack != 2'b00 || n >= 40) break;
        if (n == 3) drv_finish = 1'b1;
      end
      chk("cont_ack", ack, g);
    end
    req = 2'b00;
    chk("cont_onehot", both, 0);
    repeat (2) @(negedge clk);
    last_m = 1'b1;

    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      d = $urandom_range(1, 24);
      t = (d > TMO);
      g = pick(r);
      run_txn(r, d, ($urandom_range(0, 3) == 0), rnd128(), rnd128(), g, t, t ? TMO + 1 : d + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
